// File: rtl/codec_i2c_cfg_seq_if.sv
// Host-side request/status bus and codec control-port pad signals for codec_i2c_cfg_seq.
// master = system control / board side, slave = the sequencer.
`timescale 1ns/1ps
interface codec_i2c_cfg_seq_if #(
    parameter int unsigned NUM_REGS = 10
);
    logic                    cfg_start;
    logic [16*NUM_REGS-1:0]  cfg_table;
    logic                    wr_req;
    logic [15:0]             wr_word;
    logic                    busy;
    logic                    cfg_done;
    logic                    cfg_err;
    logic [4:0]              err_index;
    logic                    scl_oe;
    logic                    sda_oe;
    logic                    sda_in;

    modport master (
        output cfg_start, cfg_table, wr_req, wr_word, sda_in,
        input  busy, cfg_done, cfg_err, err_index, scl_oe, sda_oe
    );

    modport slave (
        input  cfg_start, cfg_table, wr_req, wr_word, sda_in,
        output busy, cfg_done, cfg_err, err_index, scl_oe, sda_oe
    );
endinterface

// File: rtl/codec_i2c_cfg_seq.sv
// I2C write-only configuration master for the WM8731: runs a register table or single
// host writes as 3-byte frames, retrying NACKed frames up to MAX_RETRY times.
`timescale 1ns/1ps
module codec_i2c_cfg_seq #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned I2C_HZ     = 100_000,
    parameter logic [6:0]  DEV_ADDR   = 7'h1A,
    parameter int unsigned NUM_REGS   = 10,
    parameter int unsigned MAX_RETRY  = 3,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic                   sys_clk50MHz,
    input  logic                   sys_rst_n,
    codec_i2c_cfg_seq_if.slave     bus
);

    localparam int unsigned DIV        = CLK_HZ / (4 * I2C_HZ);
    localparam int unsigned CNT_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [4:0]  LAST_IDX   = 5'(NUM_REGS - 1);
    localparam logic [4:0]  SINGLE_IDX = 5'd31;
    localparam logic [3:0]  RETRY_LIM  = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_BYTE, S_ACK, S_STOP, S_GAP, S_NEXT
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [1:0]         q, q_nx;
    logic [2:0]         bit_idx, bit_nx;
    logic [1:0]         byte_idx, byte_nx;
    logic [4:0]         idx, idx_nx;
    logic [3:0]         retry, retry_nx;
    logic               nack, nack_nx;
    logic               single, single_nx;
    logic [15:0]        word, word_nx;
    logic               auto_pend, auto_nx;
    logic [1:0]         sda_sync;
    logic               busy, busy_nx;
    logic               cfg_done, done_nx;
    logic               cfg_err, err_nx;
    logic [4:0]         err_index, eidx_nx;
    logic               scl_oe, sda_oe;

    logic               qtick_c;
    logic               last_q_c;
    logic               scl_c, sda_c;
    logic [7:0]         cur_byte_c;
    logic               cur_bit_c;
    logic [4:0]         idx_inc_c;

    assign qtick_c   = (cnt == CNT_W'(DIV - 1));
    assign last_q_c  = qtick_c && (q == 2'd3);
    assign idx_inc_c = idx + 5'd1;

    // Byte currently on the wire: device address, then the two halves of the control word
    always_comb begin
        cur_byte_c = word[7:0];
        case (byte_idx)
            2'd0:    cur_byte_c = {DEV_ADDR, 1'b0};
            2'd1:    cur_byte_c = word[15:8];
            default: cur_byte_c = word[7:0];
        endcase
    end
    assign cur_bit_c = cur_byte_c[3'd7 - bit_idx];

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        q_nx      = q;
        bit_nx    = bit_idx;
        byte_nx   = byte_idx;
        idx_nx    = idx;
        retry_nx  = retry;
        nack_nx   = nack;
        single_nx = single;
        word_nx   = word;
        auto_nx   = 1'b0;
        done_nx   = cfg_done;
        err_nx    = cfg_err;
        eidx_nx   = err_index;
        scl_c     = 1'b0;
        sda_c     = 1'b0;

        // Quarter-bit timebase; frozen at zero between frames so each frame starts aligned
        if (state == S_IDLE || state == S_NEXT) begin
            cnt_nx = '0;
            q_nx   = 2'd0;
        end else if (qtick_c) begin
            cnt_nx = '0;
            q_nx   = q + 2'd1;
        end else begin
            cnt_nx = cnt + CNT_W'(1);
        end

        case (state)
            S_IDLE: begin
                if (bus.cfg_start || auto_pend) begin
                    state_nx  = S_START;
                    idx_nx    = 5'd0;
                    word_nx   = bus.cfg_table[15:0];
                    single_nx = 1'b0;
                    retry_nx  = 4'd0;
                    nack_nx   = 1'b0;
                    done_nx   = 1'b0;
                    err_nx    = 1'b0;
                    bit_nx    = 3'd0;
                    byte_nx   = 2'd0;
                end else if (bus.wr_req) begin
                    state_nx  = S_START;
                    word_nx   = bus.wr_word;
                    single_nx = 1'b1;
                    retry_nx  = 4'd0;
                    nack_nx   = 1'b0;
                    bit_nx    = 3'd0;
                    byte_nx   = 2'd0;
                end
            end
            S_START: begin
                scl_c = q[1];
                sda_c = 1'b1;
                if (last_q_c) begin
                    state_nx = S_BYTE;
                    bit_nx   = 3'd0;
                    byte_nx  = 2'd0;
                end
            end
            S_BYTE: begin
                scl_c = (q == 2'd0) || (q == 2'd3);
                sda_c = ~cur_bit_c;
                if (last_q_c) begin
                    bit_nx = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nx = S_ACK;
                end
            end
            S_ACK: begin
                scl_c = (q == 2'd0) || (q == 2'd3);
                if (qtick_c && q == 2'd2) nack_nx = sda_sync[1];
                if (last_q_c) begin
                    if (nack) begin
                        state_nx = S_STOP;
                        retry_nx = retry + 4'd1;
                    end else if (byte_idx == 2'd2) begin
                        state_nx = S_STOP;
                    end else begin
                        state_nx = S_BYTE;
                        byte_nx  = byte_idx + 2'd1;
                    end
                end
            end
            S_STOP: begin
                scl_c = (q == 2'd0);
                sda_c = (q <= 2'd1);
                if (last_q_c) state_nx = S_GAP;
            end
            S_GAP: begin
                if (last_q_c) state_nx = S_NEXT;
            end
            S_NEXT: begin
                bit_nx  = 3'd0;
                byte_nx = 2'd0;
                nack_nx = 1'b0;
                if (nack) begin
                    if (retry > RETRY_LIM) begin
                        state_nx = S_IDLE;
                        err_nx   = 1'b1;
                        eidx_nx  = single ? SINGLE_IDX : idx;
                    end else begin
                        state_nx = S_START;
                    end
                end else if (single) begin
                    state_nx = S_IDLE;
                end else if (idx == LAST_IDX) begin
                    state_nx = S_IDLE;
                    done_nx  = 1'b1;
                end else begin
                    state_nx = S_START;
                    idx_nx   = idx_inc_c;
                    word_nx  = bus.cfg_table[{idx_inc_c, 4'b0000} +: 16];
                    retry_nx = 4'd0;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        busy_nx = (state_nx != S_IDLE);
    end

    always_ff @(posedge sys_clk50MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            q         <= 2'd0;
            bit_idx   <= 3'd0;
            byte_idx  <= 2'd0;
            idx       <= 5'd0;
            retry     <= 4'd0;
            nack      <= 1'b0;
            single    <= 1'b0;
            word      <= 16'd0;
            auto_pend <= AUTO_START;
            sda_sync  <= 2'b11;
            busy      <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
            err_index <= 5'd0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            q         <= q_nx;
            bit_idx   <= bit_nx;
            byte_idx  <= byte_nx;
            idx       <= idx_nx;
            retry     <= retry_nx;
            nack      <= nack_nx;
            single    <= single_nx;
            word      <= word_nx;
            auto_pend <= auto_nx;
            sda_sync  <= {sda_sync[0], bus.sda_in};
            busy      <= busy_nx;
            cfg_done  <= done_nx;
            cfg_err   <= err_nx;
            err_index <= eidx_nx;
            scl_oe    <= scl_c;
            sda_oe    <= sda_c;
        end
    end

    assign bus.busy      = busy;
    assign bus.cfg_done  = cfg_done;
    assign bus.cfg_err   = cfg_err;
    assign bus.err_index = err_index;
    assign bus.scl_oe    = scl_oe;
    assign bus.sda_oe    = sda_oe;

endmodule
